// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the multi-digit seven-segment display.
// Patterns are active-low: bit 7 = DP, bits 6:0 = g..a; DP is off in every constant.
// The table index is the 4-bit digit value (0..F).
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      ENCODE  = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Entry 0 is the rightmost element: 0,1,...,9,A,b,C,d,E,F
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg_nibble_encode.sv
// Purpose: map one 4-bit digit to its active-low segment pattern (DP off).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input nibble.
module seg_nibble_encode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seven_seg_display.sv
// Purpose: binary value -> NUM_DIGITS active-low segment fields (decimal via double-dabble, or hex).
// Latency: load at t -> disp/done at t+VALUE_W+2 (decimal) or t+2 (hex).
// Backpressure: load is only accepted in IDLE (busy low); loads while busy are dropped.
module seven_seg_display
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int VALUE_W    = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [VALUE_W-1:0]      value,
   input  logic                    load,
   input  logic                    hex_mode,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [NUM_DIGITS*8-1:0] disp
);

   localparam int BCD_W = NUM_DIGITS * 4;
   localparam int CNT_W = $clog2(VALUE_W + 1);
   localparam int EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_W - 1);

   state_t                  state, state_nxt;
   logic                    accept, step, encode;
   logic [CNT_W-1:0]        cnt;
   logic [VALUE_W-1:0]      val_q;
   logic [BCD_W-1:0]        bcd_q, bcd_adj;
   logic                    hex_q, blank_q, ovf_q;
   logic [NUM_DIGITS-1:0]   dp_q;
   logic [EXT_W-1:0]        val_ext;
   logic [BCD_W-1:0]        nib;
   logic                    hex_ovf, ovf_res, seen;
   logic [NUM_DIGITS-1:0]   lz;
   logic [NUM_DIGITS*8-1:0] enc, disp_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and per-state datapath strobes
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      encode    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               accept    = 1'b1;
               state_nxt = hex_mode ? ENCODE : CONVERT;
            end
         end
         CONVERT: begin
            step = 1'b1;
            if (cnt == LAST) state_nxt = ENCODE;
         end
         ENCODE: begin
            encode    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   // Select digit source; hex digits beyond the value width read as zero
   always_comb begin
      val_ext = EXT_W'(val_q);
      hex_ovf = |(val_ext >> BCD_W);
      nib     = hex_q ? val_ext[BCD_W-1:0] : bcd_q;
      ovf_res = hex_q ? hex_ovf : ovf_q;
   end

   // Leading-zero map: digit i is a leading zero if it and all digits above are zero
   always_comb begin
      seen = 1'b0;
      lz   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (nib[i*4 +: 4] != 4'd0) seen = 1'b1;
         if (i != 0 && !seen) lz[i] = 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
         seg_nibble_encode u_enc (
            .nibble (nib[g*4 +: 4]),
            .seg    (enc[g*8 +: 8])
         );
      end
   endgenerate

   // Override priority: dash on overflow, then blanking, then the DP on top of either
   always_comb begin
      disp_nxt = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (ovf_res)                disp_nxt[i*8 +: 8] = SEG_DASH;
         else if (blank_q && lz[i])  disp_nxt[i*8 +: 8] = SEG_BLANK;
         else                        disp_nxt[i*8 +: 8] = enc[i*8 +: 8];
         if (dp_q[i]) disp_nxt[i*8 + 7] = 1'b0;
      end
   end

   // Datapath: capture on load, one shift per CONVERT cycle, publish in ENCODE
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         val_q    <= '0;
         bcd_q    <= '0;
         hex_q    <= 1'b0;
         blank_q  <= 1'b0;
         dp_q     <= '0;
         ovf_q    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         disp     <= '1;
      end else begin
         busy <= (state_nxt != IDLE);
         done <= encode;
         if (accept) begin
            val_q   <= value;
            hex_q   <= hex_mode;
            blank_q <= blank_lz;
            dp_q    <= dp_mask;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt     <= '0;
         end
         if (step) begin
            {bcd_q, val_q} <= {bcd_adj[BCD_W-2:0], val_q, 1'b0};
            ovf_q          <= ovf_q | bcd_adj[BCD_W-1];
            cnt            <= cnt + CNT_W'(1);
         end
         if (encode) begin
            disp     <= disp_nxt;
            overflow <= ovf_res;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display with default parameters (6 digits, 20-bit value).
// Latencies are counted in edges after the load edge t: a value seen at the negedge
// following edge t+k-1 is the value sampled by edge t+k.
module tb_seven_seg_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] value;
   logic        load;
   logic        hex_mode;
   logic        blank_lz;
   logic [5:0]  dp_mask;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [47:0] disp;

   int          errors = 0;
   int          checks = 0;
   logic [47:0] exp_prev;

   seven_seg_display #(.NUM_DIGITS(6), .VALUE_W(20)) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .load     (load),
      .hex_mode (hex_mode),
      .blank_lz (blank_lz),
      .dp_mask  (dp_mask),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .disp     (disp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one load from a negedge; optionally inject a second load or a reset at
   // offset k. Returns the latency index of the done pulse (0 if none within budget).
   task automatic run_op(input logic [19:0] v, input logic hx, input logic blz,
                         input logic [5:0] dp, input int load2_k, input int rst_k,
                         output int lat);
      value    = v;
      hex_mode = hx;
      blank_lz = blz;
      dp_mask  = dp;
      load     = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check("busy_rise", 64'(busy), 64'd1);
            check("done_prev_low", 64'(done), 64'd0);
         end
         if (k == 3 && rst_k == 0) check("disp_hold", 64'(disp), 64'(exp_prev));
         if (k == load2_k) begin
            value    = 20'd7;
            hex_mode = 1'b1;
            load     = 1'b1;
         end
         if (k == load2_k + 1) load = 1'b0;
         if (k == rst_k) rst = 1'b1;
         if (rst_k != 0 && k == rst_k + 1) begin
            rst = 1'b0;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_disp", 64'(disp), 64'hFFFF_FFFF_FFFF);
         end
         if (done) lat = k;
      end
   endtask

   task automatic op(input string tag, input logic [19:0] v, input logic hx,
                     input logic blz, input logic [5:0] dp, input int load2_k,
                     input logic [47:0] exp_d, input logic exp_o, input int exp_lat);
      int lat;
      run_op(v, hx, blz, dp, load2_k, 0, lat);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_disp"}, 64'(disp), 64'(exp_d));
      check({tag, "_ovf"}, 64'(overflow), 64'(exp_o));
      exp_prev = exp_d;
   endtask

   initial begin
      int lat;
      rst      = 1'b1;
      load     = 1'b1;
      value    = 20'd9;
      hex_mode = 1'b0;
      blank_lz = 1'b0;
      dp_mask  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      load = 1'b0;
      check("reset_disp", 64'(disp), 64'hFFFF_FFFF_FFFF);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      check("reset_load_ignored", 64'(busy), 64'd0);
      exp_prev = 48'hFFFF_FFFF_FFFF;

      // Back-to-back: each op starts on the negedge where the previous done is high
      op("dec1234",  20'd1234,    1'b0, 1'b1, 6'b000000, 0, 48'hFFFF_F9A4_B099, 1'b0, 22);
      op("dec0_nb",  20'd0,       1'b0, 1'b0, 6'b000000, 0, 48'hC0C0_C0C0_C0C0, 1'b0, 22);
      op("dec0_bl",  20'd0,       1'b0, 1'b1, 6'b000000, 0, 48'hFFFF_FFFF_FFC0, 1'b0, 22);
      op("dec0_dp",  20'd0,       1'b0, 1'b1, 6'b000100, 0, 48'hFFFF_FF7F_FFC0, 1'b0, 22);
      op("hexABCDE", 20'hABCDE,   1'b1, 1'b0, 6'b000000, 0, 48'hC088_83C6_A186, 1'b0, 2);
      op("hexF_bl",  20'h0000F,   1'b1, 1'b1, 6'b100000, 0, 48'h7FFF_FFFF_FF8E, 1'b0, 2);
      op("ovf1M",    20'd1000000, 1'b0, 1'b1, 6'b000000, 0, 48'hBFBF_BFBF_BFBF, 1'b1, 22);
      op("dec999999",20'd999999,  1'b0, 1'b1, 6'b000000, 0, 48'h9898_9898_9898, 1'b0, 22);
      op("ovfmax_dp",20'd1048575, 1'b0, 1'b0, 6'b000001, 0, 48'hBFBF_BFBF_BF3F, 1'b1, 22);
      op("dec4321_l2",20'd4321,   1'b0, 1'b1, 6'b000000, 5, 48'hFFFF_99B0_A4F9, 1'b0, 22);

      // Reset mid-conversion: no done pulse, outputs return to reset values
      run_op(20'd55, 1'b0, 1'b0, 6'b000000, 0, 10, lat);
      check("rst_no_done", 64'(lat), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      exp_prev = 48'hFFFF_FFFF_FFFF;

      op("dec7_after_rst", 20'd7, 1'b0, 1'b0, 6'b000000, 0, 48'hC0C0_C0C0_C0F8, 1'b0, 22);

      @(negedge clk);
      check("done_pulse_end", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_display.md
# seven_seg_display

Multi-digit seven-segment display controller and parametrised successor to the single-digit decoder. It accepts a binary value with a load strobe and converts it to decimal using an iterative double-dabble FSM, or to hexadecimal in a single pass. It then drives `NUM_DIGITS` active-low 8-bit segment fields with leading-zero blanking, decimal-point control and overflow indication. It sits between the lab's datapath and the board HEX displays.

## Interface
- `NUM_DIGITS`, default 6: number of display digits, legal range 1..8.
- `VALUE_W`, default 20: width of the binary input, legal range 1..32.
- `clk` input 1: single system clock.
- `rst` input 1: synchronous, active-high reset.
- `value` input `VALUE_W`: unsigned binary value, sampled on an accepted load.
- `load` input 1: start request, accepted only in IDLE.
- `hex_mode` input 1: 1 selects hexadecimal, 0 selects decimal; sampled on load.
- `blank_lz` input 1: 1 blanks leading zeros; sampled on load.
- `dp_mask` input `NUM_DIGITS`: bit i lights the DP of digit i; sampled on load.
- `busy` output 1: high while not in IDLE.
- `done` output 1: one-cycle pulse when `disp` updates.
- `overflow` output 1: the last result did not fit in `NUM_DIGITS` digits.
- `disp` output `NUM_DIGITS*8`: digit i occupies bits [8i+7:8i]. Bit 7 is DP and bits 6:0 are g..a, all active-low. Digit 0 is the least significant.

## Operation
- **States:**
  - IDLE: if `load` is high and `hex_mode` is 0, go to CONVERT; if `load` is high and `hex_mode` is 1, go to ENCODE.
  - CONVERT: runs for exactly `VALUE_W` cycles, then goes to ENCODE.
  - ENCODE: lasts one cycle, then returns to IDLE.
- **Accepted load:** captures `value`, `hex_mode`, `blank_lz` and `dp_mask`. It also clears the BCD register (`NUM_DIGITS*4` bits) and the overflow flag.
- **CONVERT step (one per cycle):**
  - Add 3 to every BCD nibble that is ≥5.
  - Shift {BCD, value register} left by 1.
  - If the bit shifted out of the BCD MSB is 1, set the internal overflow flag.
- **Hex path:** nibble i equals `value[4i+3:4i]`, zero-extended. Overflow is set if any bit of `value` at or above position `4*NUM_DIGITS` is 1.
- **Segment encoding (active-low, DP off):**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98.
  - A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - blank=FF, dash=BF.
- **Leading-zero blanking:** when `blank_lz` is 1, zero digits above the most significant nonzero digit show blank. Digit 0 is never blanked.
- **Overflow:** every digit shows dash and `overflow` is 1. Leading-zero blanking does not apply.
- **Decimal points:** applied after all other rules. For each i with `dp_mask[i]`=1, bit 7 of digit i is cleared. This includes blanked and dash digits.
- **Holding outputs:** `disp` and `overflow` hold their previous values until ENCODE completes.
- **Ignored requests:** `load` is ignored while `busy` is 1; no queuing.

## Timing
- **Reset values:** `disp` = all FF, `busy` = 0, `done` = 0, `overflow` = 0, state = IDLE.
- **Reset mid-operation:** aborts the conversion and applies the reset values on the next edge. No `done` pulse is produced.
- **Decimal latency:** with load accepted at edge t:
  - `busy` is 1 from t+1 through t+`VALUE_W`+1.
  - `disp`, `overflow` and `done` take effect at t+`VALUE_W`+2, when `busy` returns to 0.
- **Hex latency:** load at t, ENCODE at t+1. `disp`, `overflow` and `done` take effect at t+2.
- **Back-to-back loads:** a `load` in the same cycle `done` is high is accepted, since the state is IDLE. The next conversion starts with no bubble.
- **Output registers:** all outputs are registered, with no combinational path from the inputs.

## Structure
- **Package `seven_seg_pkg`:**
  - state enum {IDLE, CONVERT, ENCODE}
  - segment constants SEG_BLANK=8'hFF and SEG_DASH=8'hBF
  - the 16-entry digit pattern constants
- **Sub-module `seg_nibble_encode`:** combinational, 4-bit nibble to 8-bit pattern using the hex table. Instantiated `NUM_DIGITS` times through generate. Blanking, dash and DP overrides are applied in the top level.
- **Counter:** the CONVERT cycle counter is `$clog2(VALUE_W+1)` bits wide.

## Test plan
1. Assert `rst` for 2 cycles, then release → `disp`=FFFFFFFFFFFF, `busy`=0, `done`=0, `overflow`=0. A `load` asserted during `rst` is ignored.
2. Decimal, `value`=1234, `blank_lz`=1, `dp_mask`=0 → `done` at t+22. Digits 5..0 = FF,FF,F9,A4,B0,99 and `overflow`=0.
3. `value`=0 with `blank_lz`=0 → all C0. `value`=0 with `blank_lz`=1 → digit 0 = C0, others FF. `dp_mask`=6'b000100 on the latter → digit 2 = 7F.
4. Hex, `value`=20'hABCDE, `blank_lz`=0 → `done` at t+2. Digits 5..0 = C0,88,83,C6,A1,86.
5. Overflow:
   - `NUM_DIGITS`=6, decimal `value`=1_000_000 → all digits BF, `overflow`=1.
   - A following load of 999_999 → all 98, `overflow`=0.
6. Control edge cases:
   - A second `load` at t+5 during decimal conversion is ignored; result and timing are unchanged.
   - `rst` at t+10 → no `done` pulse, `disp` all FF, `busy`=0 at t+11.
